// File: rtl/array_heap_if.sv
// rtl/array_heap_if.sv - request/response handshake bundle between core and array heap
interface array_heap_if #(
  parameter int WIDTH = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_array;
  logic [WIDTH-1:0] req_index;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [WIDTH-1:0] live_count;

  modport master (
    output req_valid, req_op, req_array, req_index, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error, live_count
  );

  modport slave (
    input  req_valid, req_op, req_array, req_index, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error, live_count
  );
endinterface

// File: rtl/array_heap.sv
// rtl/array_heap.sv - array heap responder: alloc/free/push/pop/read/write/size over valid/ready
module array_heap #(
  parameter int WIDTH   = 12,
  parameter int NARRAYS = 4,
  parameter int NAREA   = 3
) (
  input logic         clock,
  input logic         reset,
  array_heap_if.slave bus
);
  localparam int DEPTH = NARRAYS * NAREA;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (NARRAYS > 1) ? $clog2(NARRAYS) : 1;

  localparam logic [WIDTH-1:0] N_ARR  = WIDTH'(NARRAYS);
  localparam logic [WIDTH-1:0] N_AREA = WIDTH'(NAREA);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  localparam logic [2:0] OP_ALLOC = 3'd0;
  localparam logic [2:0] OP_FREE  = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;
  localparam logic [2:0] OP_SIZE  = 3'd6;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] arr_q;
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rd_data_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0]   size_q  [NARRAYS];
  logic [WIDTH-1:0]   size_d  [NARRAYS];
  logic [WIDTH-1:0]   stack_q [NARRAYS];
  logic [WIDTH-1:0]   stack_d [NARRAYS];
  logic [NARRAYS-1:0] live_q;
  logic [NARRAYS-1:0] live_d;
  logic [WIDTH-1:0]   top_q, top_d;
  logic [WIDTH-1:0]   fresh_q, fresh_d;
  logic [WIDTH-1:0]   live_count_q, live_count_d;

  logic             rsp_valid_q;
  logic             rsp_error_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             accept;
  logic [IW-1:0]    req_sel;
  logic [WIDTH-1:0] req_elem;
  logic [AW-1:0]    rd_addr;

  logic [IW-1:0]    sel;
  logic [IW-1:0]    alloc_sel;
  logic             cur_live;
  logic [WIDTH-1:0] cur_size;
  logic             alloc_from_stack;
  logic [WIDTH-1:0] alloc_id;
  logic             ex_ok;
  logic [WIDTH-1:0] ex_data;
  logic [WIDTH-1:0] wr_elem;
  logic [AW-1:0]    wr_addr;
  logic             mem_we;

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.live_count = live_count_q;

  // Heap read address for the incoming request; POP reads the element at size-1
  always_comb begin
    req_sel = '0;
    if (bus.req_array < N_ARR) req_sel = bus.req_array[IW-1:0];
    req_elem = (bus.req_op == OP_POP) ? size_q[req_sel] - ONE : bus.req_index;
    rd_addr  = '0;
    if ((bus.req_array < N_ARR) && (req_elem < N_AREA))
      rd_addr = AW'(bus.req_array) * AW'(NAREA) + AW'(req_elem);
  end

  // Request checks and response value for the registered request
  always_comb begin
    sel = '0;
    if (arr_q < N_ARR) sel = arr_q[IW-1:0];
    cur_live         = (arr_q < N_ARR) && live_q[sel];
    cur_size         = size_q[sel];
    alloc_from_stack = (top_q != '0);
    alloc_id         = alloc_from_stack ? stack_q[IW'(top_q - ONE)] : fresh_q;
    alloc_sel        = alloc_id[IW-1:0];
    ex_ok            = 1'b0;
    ex_data          = '0;
    wr_elem          = idx_q;
    case (op_q)
      OP_ALLOC: begin
        ex_ok   = alloc_from_stack || (fresh_q < N_ARR);
        ex_data = alloc_id;
      end
      OP_FREE:  ex_ok = cur_live;
      OP_PUSH: begin
        ex_ok   = cur_live && (cur_size < N_AREA);
        wr_elem = cur_size;
      end
      OP_POP: begin
        ex_ok   = cur_live && (cur_size != '0);
        ex_data = rd_data_q;
      end
      OP_READ: begin
        ex_ok   = cur_live && (idx_q < cur_size);
        ex_data = rd_data_q;
      end
      OP_WRITE: ex_ok = cur_live && (idx_q < N_AREA);
      OP_SIZE: begin
        ex_ok   = cur_live;
        ex_data = cur_size;
      end
      default: ex_ok = 1'b0;
    endcase
    if (!ex_ok) ex_data = '0;
    wr_addr = AW'(arr_q) * AW'(NAREA) + AW'(wr_elem);
    mem_we  = (state_q == EXEC) && !reset && ex_ok &&
              ((op_q == OP_PUSH) || (op_q == OP_WRITE));
  end

  // Bookkeeping next state, applied only when a checked request commits
  always_comb begin
    size_d       = size_q;
    stack_d      = stack_q;
    live_d       = live_q;
    top_d        = top_q;
    fresh_d      = fresh_q;
    live_count_d = live_count_q;
    if (ex_ok) begin
      case (op_q)
        OP_ALLOC: begin
          if (alloc_from_stack) top_d = top_q - ONE;
          else                  fresh_d = fresh_q + ONE;
          size_d[alloc_sel] = '0;
          live_d[alloc_sel] = 1'b1;
          live_count_d      = live_count_q + ONE;
        end
        OP_FREE: begin
          live_d[sel]              = 1'b0;
          stack_d[top_q[IW-1:0]]   = arr_q;
          top_d                    = top_q + ONE;
          live_count_d             = live_count_q - ONE;
        end
        OP_PUSH:  size_d[sel] = cur_size + ONE;
        OP_POP:   size_d[sel] = cur_size - ONE;
        OP_WRITE: if (idx_q >= cur_size) size_d[sel] = idx_q + ONE;
        default:  size_d[sel] = cur_size;
      endcase
    end
  end

  // Heap RAM: committed writes in EXEC, synchronous read at request acceptance
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_addr] <= data_q;
    if (accept) rd_data_q <= mem_q[rd_addr];
  end

  // Transaction FSM: capture request, commit once in EXEC, hold response until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      live_q       <= '0;
      top_q        <= '0;
      fresh_q      <= '0;
      live_count_q <= '0;
      for (int i = 0; i < NARRAYS; i++) size_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.req_op;
            arr_q   <= bus.req_array;
            idx_q   <= bus.req_index;
            data_q  <= bus.req_data;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          size_q       <= size_d;
          stack_q      <= stack_d;
          live_q       <= live_d;
          top_q        <= top_d;
          fresh_q      <= fresh_d;
          live_count_q <= live_count_d;
          rsp_data_q   <= ex_data;
          rsp_error_q  <= !ex_ok;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_array_heap.sv
// tb/tb_array_heap.sv - scoreboard bench for array_heap with a queue/array reference model
module tb_array_heap;
  localparam int WIDTH   = 12;
  localparam int NARRAYS = 4;
  localparam int NAREA   = 3;

  logic clock = 1'b0;
  logic reset;
  bit   bp_hold;
  int   n_cmp;
  int   n_bad;

  always #5 clock = ~clock;

  array_heap_if #(.WIDTH(WIDTH)) bus ();

  array_heap #(.WIDTH(WIDTH), .NARRAYS(NARRAYS), .NAREA(NAREA)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit               err;
    logic [WIDTH-1:0] data;
    bit               chk;
    int               lc;
    string            name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int               m_size [NARRAYS];
  bit               m_live [NARRAYS];
  logic [WIDTH-1:0] m_mem  [NARRAYS][NAREA];
  bit               m_def  [NARRAYS][NAREA];
  int               m_free [$];
  int               m_fresh;
  int               m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_fresh = 0;
    m_count = 0;
    for (int a = 0; a < NARRAYS; a++) begin
      m_size[a] = 0;
      m_live[a] = 0;
      for (int k = 0; k < NAREA; k++) m_def[a][k] = 0;
    end
  endtask

  task automatic model(input int op, input int arr, input int idx, input logic [WIDTH-1:0] d,
                       output exp_t e);
    bit ok;
    bit lv;
    int id;
    ok     = 0;
    e.data = '0;
    e.chk  = 1;
    lv     = 0;
    if (arr < NARRAYS) lv = m_live[arr];
    case (op)
      0: begin
        ok = 1;
        if (m_free.size() > 0) id = m_free.pop_back();
        else if (m_fresh < NARRAYS) begin id = m_fresh; m_fresh++; end
        else ok = 0;
        if (ok) begin
          m_size[id] = 0;
          m_live[id] = 1;
          m_count++;
          e.data = WIDTH'(id);
        end
      end
      1: if (lv) begin
        ok = 1;
        m_live[arr] = 0;
        m_free.push_back(arr);
        m_count--;
      end
      2: if (lv && m_size[arr] < NAREA) begin
        ok = 1;
        m_mem[arr][m_size[arr]] = d;
        m_def[arr][m_size[arr]] = 1;
        m_size[arr]++;
      end
      3: if (lv && m_size[arr] > 0) begin
        ok = 1;
        m_size[arr]--;
        e.data = m_mem[arr][m_size[arr]];
        e.chk  = m_def[arr][m_size[arr]];
      end
      4: if (lv && idx < m_size[arr]) begin
        ok = 1;
        e.data = m_mem[arr][idx];
        e.chk  = m_def[arr][idx];
      end
      5: if (lv && idx < NAREA) begin
        ok = 1;
        for (int k = m_size[arr]; k < idx; k++) m_def[arr][k] = 0;
        m_mem[arr][idx] = d;
        m_def[arr][idx] = 1;
        if (idx + 1 > m_size[arr]) m_size[arr] = idx + 1;
      end
      6: if (lv) begin
        ok = 1;
        e.data = WIDTH'(m_size[arr]);
      end
      default: ok = 0;
    endcase
    e.err = !ok;
    if (!ok) begin
      e.data = '0;
      e.chk  = 1;
    end
    e.lc = m_count;
  endtask

  task automatic issue(input string name, input int op, input int arr, input int idx,
                       input int d);
    exp_t e;
    int   n;
    model(op, arr, idx, WIDTH'(d), e);
    e.name = name;
    sb.push_back(e);
    bus.req_op    = op[2:0];
    bus.req_array = WIDTH'(arr);
    bus.req_index = WIDTH'(idx);
    bus.req_data  = WIDTH'(d);
    bus.req_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout %s: req_ready stayed 0", name);
        void'(sb.pop_back());
        break;
      end
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("ready_in_reset", 32'(bus.req_ready), 0);
    reset = 1'b0;
    model_reset();
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 1);
    check("rsp_valid_reset", 32'(bus.rsp_valid), 0);
    check("rsp_data_reset", 32'(bus.rsp_data), 0);
    check("rsp_error_reset", 32'(bus.rsp_error), 0);
    check("live_count_reset", 32'(bus.live_count), 0);
  endtask

  // Response ready: random backpressure unless a test pins it low
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      bus.rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every response handshake is compared with the oldest expectation
  always @(negedge clock) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data %0d error %0d expected no response",
                 bus.rsp_data, bus.rsp_error);
      end else begin
        mon_e = sb.pop_front();
        check({"err_", mon_e.name}, 32'(bus.rsp_error), 32'(mon_e.err));
        if (mon_e.chk) check({"data_", mon_e.name}, 32'(bus.rsp_data), 32'(mon_e.data));
        check({"lc_", mon_e.name}, 32'(bus.live_count), 32'(mon_e.lc));
      end
    end
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int n;
    int r;
    int op;
    int arr;
    int idx;
    n_cmp         = 0;
    n_bad         = 0;
    bp_hold       = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_array = '0;
    bus.req_index = '0;
    bus.req_data  = '0;
    @(posedge clock);
    #1;
    do_reset();

    issue("alloc0", 0, 0, 0, 0);
    issue("alloc1", 0, 0, 0, 0);
    drain();
    check("live_count_two", 32'(bus.live_count), 2);

    issue("push1", 2, 0, 0, 1);
    issue("push2", 2, 0, 0, 2);
    issue("pop_2", 3, 0, 0, 0);
    issue("pop_1", 3, 0, 0, 0);
    issue("pop_empty", 3, 0, 0, 0);
    issue("size_0", 6, 0, 0, 0);
    drain();

    do_reset();
    for (int i = 0; i < 5; i++) issue($sformatf("alloc_fill%0d", i), 0, 0, 0, 0);
    issue("free2", 1, 2, 0, 0);
    issue("free1", 1, 1, 0, 0);
    issue("lifo_1", 0, 0, 0, 0);
    issue("lifo_2", 0, 0, 0, 0);
    issue("free1_again", 1, 1, 0, 0);
    issue("free1_twice", 1, 1, 0, 0);
    drain();

    do_reset();
    issue("alloc_w", 0, 0, 0, 0);
    issue("write_i2", 5, 0, 2, 7);
    issue("size_3", 6, 0, 0, 0);
    issue("read_i2", 4, 0, 2, 0);
    issue("write_i3", 5, 0, 3, 9);
    issue("read_i3", 4, 0, 3, 0);
    issue("push_full", 2, 0, 0, 5);
    issue("op7", 7, 0, 0, 0);
    issue("bad_id", 6, 4, 0, 0);
    drain();

    bp_hold = 1;
    issue("pop_bp", 3, 0, 0, 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.rsp_valid && n < 10);
    check("bp_rsp_valid_seen", 32'(bus.rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_valid_hold", 32'(bus.rsp_valid), 1);
      check("bp_data_hold", 32'(bus.rsp_data), 7);
      check("bp_ready_low", 32'(bus.req_ready), 0);
    end
    bp_hold = 0;
    drain();
    issue("size_after_bp", 6, 0, 0, 0);
    drain();

    bus.req_op    = 3'd0;
    bus.req_array = '0;
    bus.req_valid = 1'b1;
    @(negedge clock);
    check("exec_reset_ready", 32'(bus.req_ready), 1);
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("exec_reset_no_rsp", 32'(bus.rsp_valid), 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("exec_reset_lc", 32'(bus.live_count), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("exec_reset_quiet", 32'(bus.rsp_valid), 0);
    end
    @(posedge clock);
    #1;
    issue("alloc_after_reset", 0, 0, 0, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 20) op = 0;
      else if (r < 30) op = 1;
      else if (r < 50) op = 2;
      else if (r < 62) op = 3;
      else if (r < 74) op = 4;
      else if (r < 86) op = 5;
      else if (r < 96) op = 6;
      else             op = 7;
      arr = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 4095) : $urandom_range(0, 3);
      idx = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 4095) : $urandom_range(0, 3);
      issue($sformatf("rnd%0d_op%0d", i, op), op, arr, idx, $urandom_range(0, 4095));
    end
    drain();
    check("final_live_count", 32'(bus.live_count), 32'(m_count));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
